m_wb_uart_tx: RTL and testbench

Hardware UART transmitter with a Wishbone responder interface, for the midgetv IO space next to the bitbang UART. The core writes one byte per Wishbone write. The block buffers it in a one-byte holding register, then serializes it as 8N1 on `usartTX` at a fixed baud rate set by `CLKDIV`. Software no longer times individual bits. A status read reports busy and holding-register state so firmware can poll before writing.

---
 rtl/m_wb_uart_tx_if.sv | 27 ++
 rtl/m_wb_uart_tx.sv | 151 +++++++++++++++
 tb/tb_m_wb_uart_tx.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/m_wb_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : m_wb_uart_tx_if
// Description : Wishbone responder bundle for the UART transmitter.
//               STB_I/WE_I/SEL_I/DAT_I run from the bus master to the block.
//               DAT_O (2-bit status) and ACK_O return to the master.
// Revision    : 1.0 - initial release
// ============================================================================
interface m_wb_uart_tx_if;
    logic       STB_I;
    logic       WE_I;
    logic       SEL_I;
    logic [7:0] DAT_I;
    logic [1:0] DAT_O;
    logic       ACK_O;

    modport master (
        output STB_I, WE_I, SEL_I, DAT_I,
        input  DAT_O, ACK_O
    );

    modport slave (
        input  STB_I, WE_I, SEL_I, DAT_I,
        output DAT_O, ACK_O
    );
endinterface
`default_nettype wire

// File: rtl/m_wb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : m_wb_uart_tx
// Description : Wishbone-written UART transmitter, 8N1, LSB first.
//               Each bus write loads a one-byte holding register. The byte
//               then moves to a shifter and is sent at CLKDIV clocks per bit.
//               A byte waiting in the holding register at the end of a stop
//               bit starts the next frame with no idle gap.
// Ports       : CLK_I    - system clock, rising edge
//               RST_N_I  - asynchronous active-low reset
//               bus      - Wishbone responder (STB/WE/SEL/DAT_I in,
//                          DAT_O status {hold_full, busy} and ACK_O out)
//               usartTX  - registered serial output, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module m_wb_uart_tx #(
    parameter int CLKDIV = 104
) (
    input  wire                   CLK_I,
    input  wire                   RST_N_I,
    m_wb_uart_tx_if.slave         bus,
    output logic                  usartTX
);

    localparam int              c_BW     = $clog2(CLKDIV);
    localparam logic [c_BW-1:0] c_RELOAD = c_BW'(CLKDIV - 1);
    localparam logic [c_BW-1:0] c_ONE    = c_BW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state,     w_state_nx;
    logic [7:0]      r_hold,      w_hold_nx;
    logic            r_hold_full, w_hold_full_nx;
    logic [7:0]      r_shift,     w_shift_nx;
    logic [2:0]      r_bitcnt,    w_bitcnt_nx;
    logic [c_BW-1:0] r_baudcnt,   w_baudcnt_nx;
    logic            r_tx,        w_tx_nx;

    logic w_ack;
    logic w_wr_acc;
    logic w_load;
    logic w_baud_zero;

    // A write stalls only while the holding register is occupied; reads never stall.
    assign w_ack       = bus.STB_I & ~(bus.WE_I & r_hold_full);
    assign w_wr_acc    = bus.STB_I & bus.WE_I & w_ack & bus.SEL_I;
    assign w_baud_zero = (r_baudcnt == '0);

    assign bus.ACK_O = w_ack;
    assign bus.DAT_O = {r_hold_full, (r_state != S_IDLE) | r_hold_full};
    assign usartTX   = r_tx;

    always_comb begin
        w_state_nx     = r_state;
        w_hold_nx      = r_hold;
        w_hold_full_nx = r_hold_full;
        w_shift_nx     = r_shift;
        w_bitcnt_nx    = r_bitcnt;
        w_baudcnt_nx   = r_baudcnt;
        w_tx_nx        = r_tx;
        w_load         = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_load = r_hold_full;
            end
            S_START: begin
                if (w_baud_zero) begin
                    w_tx_nx      = r_shift[0];
                    w_bitcnt_nx  = 3'd0;
                    w_baudcnt_nx = c_RELOAD;
                    w_state_nx   = S_DATA;
                end else begin
                    w_baudcnt_nx = r_baudcnt - c_ONE;
                end
            end
            S_DATA: begin
                if (w_baud_zero) begin
                    w_baudcnt_nx = c_RELOAD;
                    if (r_bitcnt != 3'd7) begin
                        // Next bit is bit 1 of the current shifter contents.
                        w_shift_nx  = {1'b0, r_shift[7:1]};
                        w_tx_nx     = r_shift[1];
                        w_bitcnt_nx = r_bitcnt + 3'd1;
                    end else begin
                        w_tx_nx    = 1'b1;
                        w_state_nx = S_STOP;
                    end
                end else begin
                    w_baudcnt_nx = r_baudcnt - c_ONE;
                end
            end
            S_STOP: begin
                if (w_baud_zero) begin
                    if (r_hold_full) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_baudcnt_nx = r_baudcnt - c_ONE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Transfer hold -> shifter and begin the start bit.
        if (w_load) begin
            w_shift_nx     = r_hold;
            w_hold_full_nx = 1'b0;
            w_tx_nx        = 1'b0;
            w_baudcnt_nx   = c_RELOAD;
            w_state_nx     = S_START;
        end

        // Never coincides with w_load: accept needs hold empty, load needs it full.
        if (w_wr_acc) begin
            w_hold_nx      = bus.DAT_I;
            w_hold_full_nx = 1'b1;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_state     <= S_IDLE;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_shift     <= 8'h00;
            r_bitcnt    <= 3'd0;
            r_baudcnt   <= '0;
            r_tx        <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_hold      <= w_hold_nx;
            r_hold_full <= w_hold_full_nx;
            r_shift     <= w_shift_nx;
            r_bitcnt    <= w_bitcnt_nx;
            r_baudcnt   <= w_baudcnt_nx;
            r_tx        <= w_tx_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m_wb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_wb_uart_tx
// Description : Self-checking bench for m_wb_uart_tx with CLKDIV=4.
//               Expected serial waveforms come from an arithmetic frame model
//               (start slot, eight LSB-first data slots, stop slot) applied to
//               a queue of bytes the bench has written.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_wb_uart_tx;

    localparam int c_CLKDIV = 4;
    localparam int c_FRAME  = 10 * c_CLKDIV;

    logic clk;
    logic rst_n;
    logic tx;

    int checks;
    int errors;

    logic [7:0] exp_q[$];

    m_wb_uart_tx_if bus ();

    m_wb_uart_tx #(.CLKDIV(c_CLKDIV)) dut (
        .CLK_I   (clk),
        .RST_N_I (rst_n),
        .bus     (bus.slave),
        .usartTX (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line level t cycles after the start bit begins, for byte b.
    function automatic logic model_bit(input logic [7:0] b, input int t);
        int slot;
        slot = t / c_CLKDIV;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [7:0] b);
        int guard;
        bus.STB_I = 1'b1;
        bus.WE_I  = 1'b1;
        bus.SEL_I = 1'b1;
        bus.DAT_I = b;
        #1;
        guard = 0;
        while (bus.ACK_O !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        check("wr_ack", {31'd0, bus.ACK_O}, 32'd1);
        tick();
        exp_q.push_back(b);
        bus.STB_I = 1'b0;
        bus.WE_I  = 1'b0;
    endtask

    // Called right after the edge that accepted (or will transfer) the first byte.
    task automatic check_stream(input int nframes);
        logic [7:0] b;
        for (int f = 0; f < nframes; f++) begin
            check($sformatf("frame_queue f=%0d", f), {31'd0, exp_q.size() > 0}, 32'd1);
            b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            for (int t = 0; t < c_FRAME; t++) begin
                tick();
                check($sformatf("tx b=%02h t=%0d", b, t), {31'd0, tx}, {31'd0, model_bit(b, t)});
                check($sformatf("busy b=%02h t=%0d", b, t), {31'd0, bus.DAT_O[0]}, 32'd1);
            end
        end
    endtask

    task automatic wb_read(input string tag, input logic [1:0] exp_stat);
        bus.STB_I = 1'b1;
        bus.WE_I  = 1'b0;
        #1;
        check({tag, "_ack"}, {31'd0, bus.ACK_O}, 32'd1);
        check({tag, "_stat"}, {30'd0, bus.DAT_O}, {30'd0, exp_stat});
        bus.STB_I = 1'b0;
    endtask

    initial begin
        int         stalls;
        int         gap;
        logic [7:0] x;
        logic [7:0] y;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.STB_I = 1'b0;
        bus.WE_I  = 1'b0;
        bus.SEL_I = 1'b0;
        bus.DAT_I = 8'h00;

        // Reset state
        repeat (2) tick();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_stat", {30'd0, bus.DAT_O}, 32'd0);
        check("rst_ack_idle", {31'd0, bus.ACK_O}, 32'd0);
        bus.STB_I = 1'b1;
        #1;
        check("rst_ack_follow", {31'd0, bus.ACK_O}, 32'd1);
        bus.STB_I = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_tx", {31'd0, tx}, 32'd1);
        end

        // Single byte 0x55
        wb_write(8'h55);
        check_stream(1);
        tick();
        check("single_busy_end", {31'd0, bus.DAT_O[0]}, 32'd0);

        // Lane select off: acknowledged and discarded
        bus.STB_I = 1'b1;
        bus.WE_I  = 1'b1;
        bus.SEL_I = 1'b0;
        bus.DAT_I = 8'h00;
        #1;
        check("sel0_ack", {31'd0, bus.ACK_O}, 32'd1);
        tick();
        bus.STB_I = 1'b0;
        bus.WE_I  = 1'b0;
        bus.SEL_I = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("sel0_tx", {31'd0, tx}, 32'd1);
            check("sel0_stat", {30'd0, bus.DAT_O}, 32'd0);
        end

        // Back-to-back 0xA5, 0x3C, 0xFF with strobe held
        bus.STB_I = 1'b1;
        bus.WE_I  = 1'b1;
        bus.SEL_I = 1'b1;
        bus.DAT_I = 8'hA5;
        #1;
        check("b2b_ack_a5", {31'd0, bus.ACK_O}, 32'd1);
        tick();
        exp_q.push_back(8'hA5);
        fork
            begin
                bus.DAT_I = 8'h3C;
                #1;
                check("b2b_stall_3c", {31'd0, bus.ACK_O}, 32'd0);
                tick();
                check("b2b_ack_3c", {31'd0, bus.ACK_O}, 32'd1);
                tick();
                exp_q.push_back(8'h3C);
                bus.DAT_I = 8'hFF;
                #1;
                stalls = 0;
                while (bus.ACK_O !== 1'b1 && stalls < 200) begin
                    tick();
                    stalls++;
                end
                check("b2b_ff_stall_cycles", stalls, 32'd39);
                tick();
                exp_q.push_back(8'hFF);
                bus.STB_I = 1'b0;
                bus.WE_I  = 1'b0;
            end
            check_stream(3);
        join
        tick();
        check("b2b_busy_end", {31'd0, bus.DAT_O[0]}, 32'd0);

        // Status poll during a frame with a pending byte
        x = 8'($urandom);
        y = 8'($urandom);
        wb_write(x);
        fork
            check_stream(2);
            begin
                tick();
                wb_write(y);
                wb_read("poll_pending", 2'b11);
                repeat (40) tick();
                wb_read("poll_shifting", 2'b01);
                repeat (40) tick();
                wb_read("poll_done", 2'b00);
            end
        join

        // Randomized single frames with random idle gaps
        for (int r = 0; r < 4; r++) begin
            gap = int'($urandom_range(0, 12));
            repeat (gap) tick();
            wb_write(8'($urandom));
            check_stream(1);
            tick();
            check("rand_busy_end", {31'd0, bus.DAT_O[0]}, 32'd0);
        end

        // Reset mid-frame during data bit 3 with a byte pending
        x = 8'($urandom) & 8'hF7;
        y = 8'($urandom);
        wb_write(x);
        tick();
        wb_write(y);
        repeat (16) tick();
        check("mid_bit3", {31'd0, tx}, {31'd0, model_bit(x, 17)});
        check("mid_stat", {30'd0, bus.DAT_O}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", {31'd0, tx}, 32'd1);
        check("async_rst_stat", {30'd0, bus.DAT_O}, 32'd0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 50; i++) begin
            tick();
            check("post_rst_tx", {31'd0, tx}, 32'd1);
            check("post_rst_stat", {30'd0, bus.DAT_O}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
